colour_filter_pipe: RTL

COLOUR_FILTER_PIPE -- requirements
Module: colour_filter_pipe

---
 rtl/colour_filter_pipe.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/colour_filter_pipe.sv
// colour_filter_pipe: RGB window matcher with output modes and a per-frame
// hit counter; two-cycle fixed latency, no backpressure.
module colour_filter_pipe #(
  parameter int DW  = 8,
  parameter int NCH = 4,
  parameter int CW  = 20
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic            iVS,
  input  logic            iDVAL,
  input  logic [DW-1:0]   iR,
  input  logic [DW-1:0]   iG,
  input  logic [DW-1:0]   iB,
  input  logic [1:0]      iMODE,
  input  logic            iCFG_WE,
  input  logic [2:0]      iCFG_SEL,
  input  logic [6*DW:0]   iCFG_DATA,
  output logic            oDVAL,
  output logic [DW-1:0]   oR,
  output logic [DW-1:0]   oG,
  output logic [DW-1:0]   oB,
  output logic [NCH-1:0]  oHIT,
  output logic [CW-1:0]   oHIT_CNT,
  output logic            oCNT_STB
);

  typedef struct packed {
    logic          en;
    logic [DW-1:0] rmin;
    logic [DW-1:0] rmax;
    logic [DW-1:0] gmin;
    logic [DW-1:0] gmax;
    logic [DW-1:0] bmin;
    logic [DW-1:0] bmax;
  } win_t;

  typedef enum logic [1:0] {
    M_BYP  = 2'd0,
    M_MASK = 2'd1,
    M_BIN  = 2'd2,
    M_HL   = 2'd3
  } mode_e;

  localparam logic [DW-1:0] ZERO = '0;
  localparam logic [DW-1:0] ONES = '1;
  localparam win_t WIN_RST = win_t'({1'b0, ZERO, ONES,
                                     ZERO, ONES, ZERO, ONES});

  win_t           shd_q [NCH];
  win_t           shd_d [NCH];
  win_t           act_q [NCH];
  win_t           act_d [NCH];
  mode_e          mode_q, mode_d;
  logic           vs_q, vs_d;
  logic           bnd;

  logic           v1_q, v1_d;
  logic [DW-1:0]  r1_q, r1_d;
  logic [DW-1:0]  g1_q, g1_d;
  logic [DW-1:0]  b1_q, b1_d;
  logic [DW-1:0]  gray1_q, gray1_d;
  logic [NCH-1:0] hit1_q, hit1_d;
  mode_e          mode1_q, mode1_d;
  logic           any1;

  logic           v2_q, v2_d;
  logic [DW-1:0]  r2_q, r2_d;
  logic [DW-1:0]  g2_q, g2_d;
  logic [DW-1:0]  b2_q, b2_d;
  logic [NCH-1:0] hit2_q, hit2_d;

  logic           hs;
  logic [CW-1:0]  run_q, run_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           stb_q, stb_d;

  function automatic logic in_win(input win_t w,
                                  input logic [DW-1:0] r,
                                  input logic [DW-1:0] g,
                                  input logic [DW-1:0] b);
    return w.en &&
           (r >= w.rmin) && (r <= w.rmax) &&
           (g >= w.gmin) && (g <= w.gmax) &&
           (b >= w.bmin) && (b <= w.bmax);
  endfunction

  // Config: the copy takes the pre-write shadow, so a write on the
  // boundary cycle waits one more frame.
  always_comb begin
    bnd    = iVS & ~vs_q;
    vs_d   = iVS;
    shd_d  = shd_q;
    act_d  = act_q;
    mode_d = mode_q;
    if (bnd) begin
      act_d  = shd_q;
      mode_d = mode_e'(iMODE);
    end
    for (int k = 0; k < NCH; k++) begin
      if (iCFG_WE && iCFG_SEL == 3'(k)) begin
        shd_d[k] = win_t'(iCFG_DATA);
      end
    end
  end

  always_comb begin
    v1_d    = iDVAL;
    r1_d    = iR;
    g1_d    = iG;
    b1_d    = iB;
    mode1_d = mode_q;
    gray1_d = DW'(({2'b00, iR} + {1'b0, iG, 1'b0}
                  + {2'b00, iB}) >> 2);
    for (int k = 0; k < NCH; k++) begin
      hit1_d[k] = in_win(act_q[k], iR, iG, iB);
    end
  end

  always_comb begin
    any1   = |hit1_q;
    v2_d   = v1_q;
    r2_d   = '0;
    g2_d   = '0;
    b2_d   = '0;
    hit2_d = '0;
    if (v1_q) begin
      hit2_d = hit1_q;
      unique case (mode1_q)
        M_BYP: begin
          r2_d = r1_q;
          g2_d = g1_q;
          b2_d = b1_q;
        end
        M_MASK: begin
          if (any1) begin
            r2_d = r1_q;
            g2_d = g1_q;
            b2_d = b1_q;
          end
        end
        M_BIN: begin
          if (any1) begin
            r2_d = '1;
            g2_d = '1;
            b2_d = '1;
          end
        end
        M_HL: begin
          r2_d = any1 ? r1_q : gray1_q;
          g2_d = any1 ? g1_q : gray1_q;
          b2_d = any1 ? b1_q : gray1_q;
        end
      endcase
    end
  end

  // A hit sitting in stage 1 on the boundary opens the new frame.
  always_comb begin
    hs    = v1_q & any1;
    run_d = run_q;
    cnt_d = cnt_q;
    stb_d = bnd;
    if (bnd) begin
      cnt_d = run_q;
      run_d = CW'(hs);
    end else if (hs && run_q != '1) begin
      run_d = run_q + 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int k = 0; k < NCH; k++) begin
        shd_q[k] <= WIN_RST;
        act_q[k] <= WIN_RST;
      end
      mode_q  <= M_BYP;
      vs_q    <= 1'b1;
      v1_q    <= 1'b0;
      r1_q    <= '0;
      g1_q    <= '0;
      b1_q    <= '0;
      gray1_q <= '0;
      hit1_q  <= '0;
      mode1_q <= M_BYP;
      v2_q    <= 1'b0;
      r2_q    <= '0;
      g2_q    <= '0;
      b2_q    <= '0;
      hit2_q  <= '0;
      run_q   <= '0;
      cnt_q   <= '0;
      stb_q   <= 1'b0;
    end else begin
      shd_q   <= shd_d;
      act_q   <= act_d;
      mode_q  <= mode_d;
      vs_q    <= vs_d;
      v1_q    <= v1_d;
      r1_q    <= r1_d;
      g1_q    <= g1_d;
      b1_q    <= b1_d;
      gray1_q <= gray1_d;
      hit1_q  <= hit1_d;
      mode1_q <= mode1_d;
      v2_q    <= v2_d;
      r2_q    <= r2_d;
      g2_q    <= g2_d;
      b2_q    <= b2_d;
      hit2_q  <= hit2_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
    end
  end

  assign oDVAL    = v2_q;
  assign oR       = r2_q;
  assign oG       = g2_q;
  assign oB       = b2_q;
  assign oHIT     = hit2_q;
  assign oHIT_CNT = cnt_q;
  assign oCNT_STB = stb_q;

endmodule
